rf_port_arbiter: RTL
====================

Name: rf_port_arbiter

Overview:
- Shares the integer register file's write port and read port 1 between the pipeline write-back stage and an external debug requester.
- Pipeline traffic passes straight through when idle.
- A debug access raises a pipeline hold, waits for in-flight write-backs to drain, performs one register read or write, then acknowledges.
- Sits between wb_unit/id_unit and int_rf inside the core.

Parameters:
- XLEN, 32, data width.
- AR_BITS, 5, register index width.
- MAX_WAIT, 8, maximum DRAIN cycles before a debug access aborts with error (range 2..255).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- wb_we_i  in  1  pipeline write-back enable
- wb_dst_i  in  AR_BITS  pipeline write-back destination
- wb_r_i  in  XLEN  pipeline write-back data
- pipe_src1_i  in  AR_BITS  pipeline read address, port 1
- dbg_req_i  in  1  debug access request, level
- dbg_we_i  in  1  1=write, 0=read; sampled with req in IDLE
- dbg_addr_i  in  AR_BITS  debug register index
- dbg_wdata_i  in  XLEN  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_err_o  out  1  valid with ack; 1 = drain timeout, access not performed
- dbg_rdata_o  out  XLEN  read result, valid from ack until next request
- pipe_hold_o  out  1  freeze request to the pipeline (ORed into id stall)
- rf_we_o  out  1  write enable to int_rf
- rf_dst_o  out  AR_BITS  write index to int_rf
- rf_wdata_o  out  XLEN  write data to int_rf
- rf_src1_o  out  AR_BITS  read index, port 1, to int_rf
- rf_src1_q_i  in  XLEN  int_rf port 1 data; one cycle after the address

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, wait counter 0, all outputs 0, dbg_rdata_o 0, latched request cleared. A reset mid-access aborts it: no ack, no rf write.
- The write mux and read mux are combinational from the current state. In IDLE and DRAIN: rf_we_o/rf_dst_o/rf_wdata_o = wb_*, and rf_src1_o = pipe_src1_i.
- IDLE: pipe_hold_o=0. If dbg_req_i=1, latch we/addr/wdata and go to DRAIN next cycle.
- DRAIN: pipe_hold_o=1 and the counter increments.
  - wb_we_i=0: go to WRITE if latched we=1, else READ; counter cleared.
  - Counter reaches MAX_WAIT-1 with wb_we_i still 1: go to RESP with err=1.
- WRITE: pipe_hold_o=1.
  - wb_we_i=1 (late write-back): the pipeline owns the port, outputs pass through, and the state stays in WRITE.
  - Otherwise: rf_we_o = (latched addr != 0), rf_dst_o = latched addr, rf_wdata_o = latched data. Go to RESP.
  - A write to x0 completes with ack and no rf write.
- READ: pipe_hold_o=1, rf_src1_o = latched addr. Go to CAPT.
- CAPT: pipe_hold_o=1. dbg_rdata_o <= (latched addr==0) ? 0 : rf_src1_q_i. Go to RESP.
- RESP: pipe_hold_o=1, dbg_ack_o=1, dbg_err_o = latched err. Go to IDLE.
  - Requester must drop dbg_req_i by the ack cycle; req high in the following IDLE is a new request.
- Latencies without contention: write ack at cycle 3 after req sample; read ack at cycle 4. Req sample is cycle 0.
- Inputs dbg_* are ignored outside IDLE.
- pipe_hold_o deasserts the cycle after ack.

Optional Feature:
- RF_ARB_STATS_EN defined: extra output hold_cycles_o [15:0], a saturating count of cycles with pipe_hold_o=1 since reset. It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and counter are absent; function is otherwise identical.

Decomposition:
- Package rf_arb_pkg:
  - state enum {IDLE, DRAIN, WRITE, READ, CAPT, RESP};
  - localparam X0 = '0;
  - struct dbg_req_t {we, addr, wdata} for the latched request.
- One sub-module, rf_arb_wait_cnt: clear/enable counter with a terminal-count flag at MAX_WAIT-1.

Test Plan:
- Idle passthrough: wb_we_i=1, wb_dst_i=5, wb_r_i=0xDEADBEEF, no dbg req -> rf_we_o=1, rf_dst_o=5, rf_wdata_o=0xDEADBEEF same cycle; pipe_hold_o=0.
- Debug write, no contention: req we=1, addr=7, wdata=0x12345678 -> rf_we_o=1, dst=7 at cycle 2; ack=1, err=0 at cycle 3; hold=1 for cycles 1..3.
- Debug read: rf x9=0xCAFEF00D, req we=0, addr=9 -> rf_src1_o=9 at cycle 2; ack at cycle 4 with dbg_rdata_o=0xCAFEF00D.
- Drain contention: wb_we_i=1 for the first 2 DRAIN cycles, then 0 -> both pipeline writes reach rf unchanged; debug write follows; ack at cycle 5.
- Timeout: wb_we_i held 1, MAX_WAIT=8 -> ack with err=1 at cycle 9, no debug rf write.
- x0 and reset: write addr=0 -> ack, rf_we_o never 1 for dbg. Separately, rst_n=0 during READ -> next cycle IDLE, all outputs 0, no ack.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file port arbiter
package rf_arb_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_AR_BITS = 5;

    localparam logic [RF_AR_BITS-1:0] X0 = '0;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WRITE,
        READ,
        CAPT,
        RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [RF_AR_BITS-1:0] addr;
        logic [RF_XLEN-1:0]    wdata;
    } dbg_req_t;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// rtl/rf_port_arbiter_if.sv - pipeline, debug and int_rf signals around the port arbiter
interface rf_port_arbiter_if #(
    parameter int XLEN    = 32,
    parameter int AR_BITS = 5
);
    logic               wb_we_i;
    logic [AR_BITS-1:0] wb_dst_i;
    logic [XLEN-1:0]    wb_r_i;
    logic [AR_BITS-1:0] pipe_src1_i;
    logic               dbg_req_i;
    logic               dbg_we_i;
    logic [AR_BITS-1:0] dbg_addr_i;
    logic [XLEN-1:0]    dbg_wdata_i;
    logic               dbg_ack_o;
    logic               dbg_err_o;
    logic [XLEN-1:0]    dbg_rdata_o;
    logic               pipe_hold_o;
    logic               rf_we_o;
    logic [AR_BITS-1:0] rf_dst_o;
    logic [XLEN-1:0]    rf_wdata_o;
    logic [AR_BITS-1:0] rf_src1_o;
    logic [XLEN-1:0]    rf_src1_q_i;

    modport slave (
        input  wb_we_i, wb_dst_i, wb_r_i, pipe_src1_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_src1_q_i,
        output dbg_ack_o, dbg_err_o, dbg_rdata_o, pipe_hold_o,
        output rf_we_o, rf_dst_o, rf_wdata_o, rf_src1_o
    );

    modport master (
        output wb_we_i, wb_dst_i, wb_r_i, pipe_src1_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, rf_src1_q_i,
        input  dbg_ack_o, dbg_err_o, dbg_rdata_o, pipe_hold_o,
        input  rf_we_o, rf_dst_o, rf_wdata_o, rf_src1_o
    );

endinterface

// File: rtl/rf_arb_wait_cnt.sv
// rtl/rf_arb_wait_cnt.sv - drain wait counter with terminal count at MAX_WAIT-1
module rf_arb_wait_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - shares int_rf write port and read port 1 between write-back and debug
// Optional: RF_ARB_STATS_EN adds hold_cycles_o, a saturating count of pipe_hold_o cycles.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int AR_BITS  = RF_AR_BITS,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef RF_ARB_STATS_EN
    output logic [15:0] hold_cycles_o,
`endif
    rf_port_arbiter_if.slave bus
);

    state_t             state, state_n;
    dbg_req_t           req_q;
    logic               err_q;
    logic [XLEN-1:0]    rdata_q;
    logic               latch_req, set_err, capt, tc;
    logic               hold, ack;
    logic               rf_we;
    logic [AR_BITS-1:0] rf_dst, rf_src1;
    logic [XLEN-1:0]    rf_wdata;
    logic               wait_clr, wait_en;

    assign wait_en  = (state == DRAIN);
    assign wait_clr = (state_n != DRAIN);

    rf_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wait_clr),
        .en    (wait_en),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (latch_req) begin
                req_q <= '{we: bus.dbg_we_i, addr: bus.dbg_addr_i, wdata: bus.dbg_wdata_i};
                err_q <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (capt) begin
                rdata_q <= (req_q.addr == X0) ? '0 : bus.rf_src1_q_i;
            end
        end
    end

    always_comb begin
        state_n   = state;
        hold      = 1'b0;
        ack       = 1'b0;
        latch_req = 1'b0;
        set_err   = 1'b0;
        capt      = 1'b0;
        rf_we     = bus.wb_we_i;
        rf_dst    = bus.wb_dst_i;
        rf_wdata  = bus.wb_r_i;
        rf_src1   = bus.pipe_src1_i;
        case (state)
            IDLE: begin
                if (bus.dbg_req_i) begin
                    latch_req = 1'b1;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                hold = 1'b1;
                if (!bus.wb_we_i) begin
                    state_n = req_q.we ? WRITE : READ;
                end else if (tc) begin
                    set_err = 1'b1;
                    state_n = RESP;
                end
            end
            WRITE: begin
                hold = 1'b1;
                // A late write-back keeps the port; the debug write waits behind it.
                if (!bus.wb_we_i) begin
                    rf_we    = (req_q.addr != X0);
                    rf_dst   = req_q.addr;
                    rf_wdata = req_q.wdata;
                    state_n  = RESP;
                end
            end
            READ: begin
                hold    = 1'b1;
                rf_src1 = req_q.addr;
                state_n = CAPT;
            end
            CAPT: begin
                hold    = 1'b1;
                capt    = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                hold    = 1'b1;
                ack     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.pipe_hold_o = hold;
    assign bus.dbg_ack_o   = ack;
    assign bus.dbg_err_o   = ack & err_q;
    assign bus.dbg_rdata_o = rdata_q;
    assign bus.rf_we_o     = rf_we;
    assign bus.rf_dst_o    = rf_dst;
    assign bus.rf_wdata_o  = rf_wdata;
    assign bus.rf_src1_o   = rf_src1;

`ifdef RF_ARB_STATS_EN
    logic [15:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (hold && (hold_cnt != 16'hFFFF)) begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign hold_cycles_o = hold_cnt;
`endif

endmodule
